riscvlong_vec_mem_arbiter: RTL
==============================

Name: riscvlong_vec_mem_arbiter

Overview:
- Shares one data-memory port among the 4 vector-lane request/response port pairs of the 7-stage core. Sits between the core's lane ports 0..3 and a single memory port.
- Arbitrates requests round-robin and records the granted lane ID in an in-order tag FIFO.
- Routes each memory response back to the lane that issued the matching request.
- Memory responses return in request order and carry no ready signal.

Parameters:
- REQ_SZ, 67, width of a memory request message (32-bit addr, 32-bit data).
- RESP_SZ, 35, width of a memory response message (32-bit data).
- DEPTH, 4, maximum outstanding requests; also the tag FIFO depth; must be a power of 2 and ≥2.
- CNT_W, 3, width of the outstanding count, equal to clog2(DEPTH+1).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset; asynchronous, active-low.
- lane_req_msg  in  4*REQ_SZ  lane i's request at bits [i*REQ_SZ +: REQ_SZ].
- lane_req_val  in  4  per-lane request valid.
- lane_req_rdy  out  4  per-lane accept; at most one bit is high.
- lane_resp_msg  out  RESP_SZ  mem_resp_msg broadcast to all lanes.
- lane_resp_val  out  4  one-hot response valid for the owning lane.
- mem_req_msg  out  REQ_SZ  message of the granted lane.
- mem_req_val  out  1  memory request valid.
- mem_req_rdy  in  1  memory ready.
- mem_resp_msg  in  RESP_SZ  memory response.
- mem_resp_val  in  1  memory response valid.
- outstanding  out  CNT_W  number of requests in flight.
- idle  out  1  high when outstanding==0 and lane_req_val==0.
- err  out  1  sticky error: response arrived with no request outstanding.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - Priority pointer = lane 0; FIFO emptied; outstanding=0; err=0.
  - During reset the combinational outputs are lane_req_rdy=0, mem_req_val=0 and lane_resp_val=0.
  - In-flight requests are discarded; a response arriving after reset sets err.
- Arbitration is combinational, with zero-cycle request latency:
  - Eligible lanes are those with lane_req_val=1. The winner is the first eligible lane searching from ptr upward, wrapping 3→0.
  - can_issue = FIFO not full.
  - mem_req_val = any eligible & can_issue; mem_req_msg = winner's message (don't-care when invalid).
  - lane_req_rdy[winner] = mem_req_rdy & can_issue; all other bits are 0.
- Request fire = mem_req_val & mem_req_rdy. On fire:
  - The winner's ID is pushed into the FIFO.
  - ptr <= winner+1 mod 4.
  - ptr is unchanged on a non-fire cycle, including when the winner is stalled by mem_req_rdy=0.
- mem_req_val must not depend on mem_req_rdy (no combinational loop).
- Full FIFO: grants are blocked even if a response pops in the same cycle (no same-cycle bypass).
- Response routing is combinational, with zero-cycle response latency:
  - If mem_resp_val and the FIFO is not empty: lane_resp_val[head ID]=1, then pop.
  - If mem_resp_val and the FIFO is empty: lane_resp_val=0, response dropped, err<=1 until reset.
- Simultaneous push and pop on a non-full FIFO: both happen and outstanding is unchanged.
- outstanding increments on push-only and decrements on pop-only; it never exceeds DEPTH.
- FIFO pointers are log2(DEPTH) bits with natural wrap; full/empty are determined by the count.

Optional Feature:
- Macro RISCVLONG_VMEMARB_PERF_EN.
- When defined, adds the following output ports:
  - perf_grants (4*16): per-lane count of request fires.
  - perf_conflicts (16): counts cycles where ≥2 lanes are valid.
  - perf_full_stalls (16): counts cycles where a lane is valid and the FIFO is full.
- All perf counters saturate at 0xFFFF and reset to 0.
- When not defined, these ports and counters do not exist; arbitration behaviour is identical either way.

Decomposition:
- Shared package riscvlong_vmemarb_pkg contains:
  - NUM_LANES=4.
  - Lane ID typedef (2 bits).
  - REQ_SZ/RESP_SZ constants matching the VC memory message sizes for (32,32) and (32).
  - Perf counter width of 16.
- One sub-module, riscvlong_vmemarb_tag_fifo: parameterised DEPTH × 2-bit FIFO with push/pop/full/empty/count and asynchronous active-low reset.
- The round-robin picker stays inline.

Test Plan:
- Single lane: lane 2 valid with addr 0x100 and mem_req_rdy=1.
  - Expected: mem_req_val=1 and lane_req_rdy=4'b0100 the same cycle.
  - The response 1 cycle later produces lane_resp_val=4'b0100 with data passed through.
- Round-robin: all 4 lanes continuously valid, rdy=1, memory responds the next cycle.
  - Expected grant order: 0,1,2,3,0,1; each lane gets 2 grants in 8 cycles.
- Backpressure: lanes 1 and 3 valid, mem_req_rdy=0 for 3 cycles, then 1.
  - Expected: mem_req_msg stays lane 1's message, ptr is unchanged, and lane 1 fires first, then lane 3.
- Full FIFO: issue 4 requests with no responses.
  - Expected: outstanding=4, mem_req_val=0 even with lane 0 valid.
  - Then one response arrives: it goes to the oldest lane, and a grant is possible only in the following cycle.
- Out-of-band events: response with an empty FIFO → err=1, lane_resp_val=0.
  - Then assert reset_n=0 mid-burst with 2 outstanding: outputs clear immediately, and outstanding=0 after release.
- Perf build (RISCVLONG_VMEMARB_PERF_EN): all lanes valid for 10 cycles with rdy=1.
  - Expected: perf_conflicts=10, and perf_grants sums to 10 as {3,3,2,2} for lanes 0..3.

Source files
------------

// File: rtl/riscvlong_vmemarb_pkg.sv
// riscvlong_vmemarb_pkg: shared constants, lane ID type and saturating-increment helper for the vector memory arbiter
package riscvlong_vmemarb_pkg;
    localparam int NUM_LANES = 4;
    localparam int REQ_SZ    = 67;
    localparam int RESP_SZ   = 35;
    localparam int PERF_W    = 16;
    typedef logic [1:0] lane_id_t;
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction
endpackage

// File: rtl/riscvlong_vmemarb_tag_fifo.sv
// riscvlong_vmemarb_tag_fifo: in-order FIFO of granted lane IDs
// Ports: clk, reset_n (async active-low), push_i/din_i, pop_i/dout_o, full_o, empty_o, count_o.
// Push when full and pop when empty are ignored.
module riscvlong_vmemarb_tag_fifo
    import riscvlong_vmemarb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  lane_id_t         din_i,
    input  logic             pop_i,
    output lane_id_t         dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    lane_id_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q, wr_d, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == CNT_W'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= din_i;
        end
    end
endmodule

// File: rtl/riscvlong_vec_mem_arbiter.sv
// riscvlong_vec_mem_arbiter: round-robin share of one memory port among 4 vector lanes with in-order response routing
// Ports: clk, reset_n (async active-low); lane_req_msg/val/rdy (lane side requests);
//   lane_resp_msg/val (broadcast data, one-hot valid); mem_req_msg/val/rdy, mem_resp_msg/val (memory side);
//   outstanding, idle, err (sticky: response with nothing outstanding).
// Optional macro RISCVLONG_VMEMARB_PERF_EN adds perf_grants, perf_conflicts, perf_full_stalls.
module riscvlong_vec_mem_arbiter
    import riscvlong_vmemarb_pkg::*;
#(
    parameter int REQ_SZ  = riscvlong_vmemarb_pkg::REQ_SZ,
    parameter int RESP_SZ = riscvlong_vmemarb_pkg::RESP_SZ,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_LANES*REQ_SZ-1:0] lane_req_msg,
    input  logic [NUM_LANES-1:0]        lane_req_val,
    output logic [NUM_LANES-1:0]        lane_req_rdy,
    output logic [RESP_SZ-1:0]          lane_resp_msg,
    output logic [NUM_LANES-1:0]        lane_resp_val,
    output logic [REQ_SZ-1:0]           mem_req_msg,
    output logic                        mem_req_val,
    input  logic                        mem_req_rdy,
    input  logic [RESP_SZ-1:0]          mem_resp_msg,
    input  logic                        mem_resp_val,
    output logic [CNT_W-1:0]            outstanding,
    output logic                        idle,
    output logic                        err
`ifdef RISCVLONG_VMEMARB_PERF_EN
    ,
    output logic [NUM_LANES*PERF_W-1:0] perf_grants,
    output logic [PERF_W-1:0]           perf_conflicts,
    output logic [PERF_W-1:0]           perf_full_stalls
`endif
);
    lane_id_t ptr_q, ptr_d, winner, head;
    logic     err_q, err_d;
    logic     any_val, full, empty, issue, fire, resp_hit;

    // Scan from farthest to nearest offset so the nearest eligible lane wins.
    always_comb begin
        winner = ptr_q;
        for (int k = NUM_LANES - 1; k >= 0; k--)
            if (lane_req_val[ptr_q + 2'(k)]) winner = ptr_q + 2'(k);
    end

    // Combinational outputs are forced quiet while reset is held.
    assign any_val       = |lane_req_val;
    assign issue         = reset_n & any_val & ~full;
    assign fire          = issue & mem_req_rdy;
    assign resp_hit      = reset_n & mem_resp_val & ~empty;
    assign mem_req_val   = issue;
    assign mem_req_msg   = lane_req_msg[winner*REQ_SZ +: REQ_SZ];
    assign lane_req_rdy  = {3'b000, fire} << winner;
    assign lane_resp_msg = mem_resp_msg;
    assign lane_resp_val = {3'b000, resp_hit} << head;
    assign idle          = (outstanding == '0) && (lane_req_val == '0);
    assign err           = err_q;

    always_comb begin
        ptr_d = fire ? winner + 1'b1 : ptr_q;
        err_d = err_q | (mem_resp_val & empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    riscvlong_vmemarb_tag_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fire),
        .din_i   (winner),
        .pop_i   (resp_hit),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding)
    );

`ifdef RISCVLONG_VMEMARB_PERF_EN
    logic [PERF_W-1:0] grants_q [NUM_LANES];
    logic [PERF_W-1:0] conflicts_q, stalls_q;
    logic              multi;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi = (lane_req_val & (lane_req_val - 1'b1)) != '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LANES; i++) grants_q[i] <= '0;
            conflicts_q <= '0;
            stalls_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) grants_q[i] <= sat_inc(grants_q[i], fire && winner == 2'(i));
            conflicts_q <= sat_inc(conflicts_q, multi);
            stalls_q    <= sat_inc(stalls_q, any_val & full);
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_perf
        assign perf_grants[g*PERF_W +: PERF_W] = grants_q[g];
    end
    assign perf_conflicts   = conflicts_q;
    assign perf_full_stalls = stalls_q;
`endif
endmodule
